// File: rtl/tick_scheduler_pkg.sv
// tick_sched_pkg: shared FSM encoding and default sizing for the tick scheduler.
package tick_sched_pkg;
   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_RUN   = 2'd1;
   localparam logic [1:0] ST_PAUSE = 2'd2;
   localparam logic [1:0] ST_SYNC  = 2'd3;
   localparam int TS_CW = 24;
   localparam int TS_DEF_PERIOD = 1048576;
endpackage

// File: rtl/tick_scheduler_if.sv
// tick_scheduler_if: period-write handshake between the game FSM and the scheduler.
interface tick_scheduler_if #(parameter int CHW = 2, parameter int CW = 24);
   logic           cfg_valid;
   logic           cfg_ready;
   logic [CHW-1:0] cfg_ch;
   logic [CW-1:0]  cfg_period;
   logic           cfg_err;
   modport master (output cfg_valid, cfg_ch, cfg_period, input cfg_ready, cfg_err);
   modport slave  (input cfg_valid, cfg_ch, cfg_period, output cfg_ready, cfg_err);
endinterface

// File: rtl/tick_scheduler_chan.sv
// tick_chan: one programmable period counter producing a registered single-cycle tick.
module tick_chan #(
   parameter int            CW         = 24,
   parameter logic [CW-1:0] DEF_PERIOD = '0
) (
   input  logic          clk,
   input  logic          clr_n,
   input  logic          adv_i,
   input  logic          clr_cnt_i,
   input  logic          wr_en_i,
   input  logic [CW-1:0] wr_period_i,
   output logic          tick_o
);
   logic [CW-1:0] per_q, per_d, cnt_q, cnt_d;
   logic          tick_q, tick_d, live, due;
   always_comb begin
      live   = adv_i && per_q != '0;
      due    = live && cnt_q == per_q - CW'(1);
      per_d  = wr_en_i ? wr_period_i : per_q;
      // a write or a sync restarts the period and swallows any tick due on this edge
      cnt_d  = (wr_en_i || clr_cnt_i || due) ? '0 : live ? cnt_q + CW'(1) : cnt_q;
      tick_d = due && !wr_en_i && !clr_cnt_i;
   end
   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         per_q  <= DEF_PERIOD;
         cnt_q  <= '0;
         tick_q <= 1'b0;
      end else begin
         per_q  <= per_d;
         cnt_q  <= cnt_d;
         tick_q <= tick_d;
      end
   end
   assign tick_o = tick_q;
endmodule

// File: rtl/tick_scheduler.sv
// tick_scheduler: run/pause/sync FSM plus NCH independently programmable tick-enable channels.
module tick_scheduler import tick_sched_pkg::*; #(
   parameter int            NCH        = 4,
   parameter int            CW         = TS_CW,
   parameter logic [CW-1:0] DEF_PERIOD = CW'(TS_DEF_PERIOD)
) (
   input  logic             clk,
   input  logic             clr_n,
   input  logic             run_i,
   input  logic             sync_req_i,
   tick_scheduler_if.slave  cfg,
   output logic [NCH-1:0]   tick_o,
   output logic [1:0]       state_o
);
   localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;
   logic [1:0] st_q, st_d;
   logic       cfg_ready_q, cfg_err_q, fire, adv, clr_cnt;
   always_comb begin
      st_d    = sync_req_i ? ST_SYNC : run_i ? ST_RUN : (st_q == ST_IDLE) ? ST_IDLE : ST_PAUSE;
      // counting needs RUN on both sides of the edge, so a pause beats a due tick
      adv     = st_q == ST_RUN && st_d == ST_RUN;
      clr_cnt = st_d == ST_SYNC || st_q == ST_SYNC;
      fire    = cfg.cfg_valid && cfg_ready_q;
   end
   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         st_q        <= ST_IDLE;
         cfg_ready_q <= 1'b0;
         cfg_err_q   <= 1'b0;
      end else begin
         st_q        <= st_d;
         cfg_ready_q <= st_d != ST_SYNC;
         cfg_err_q   <= fire && int'(cfg.cfg_ch) >= NCH;
      end
   end
   for (genvar i = 0; i < NCH; i++) begin : g_ch
      tick_chan #(.CW(CW), .DEF_PERIOD(DEF_PERIOD)) u_chan (
         .clk         (clk),
         .clr_n       (clr_n),
         .adv_i       (adv),
         .clr_cnt_i   (clr_cnt),
         .wr_en_i     (fire && cfg.cfg_ch == CHW'(i)),
         .wr_period_i (cfg.cfg_period),
         .tick_o      (tick_o[i])
      );
   end
   assign state_o       = st_q;
   assign cfg.cfg_ready = cfg_ready_q;
   assign cfg.cfg_err   = cfg_err_q;
endmodule

// File: tb/tb_tick_scheduler.sv
// tb_tick_scheduler: directed checks of the tick scheduler with hand-derived tick timing.
module tb_tick_scheduler;
   logic       clk = 1'b0, clr_n = 1'b0, run = 1'b0, sync_req = 1'b0, run2 = 1'b0;
   logic [3:0] tick, exp4;
   logic [1:0] state, state2;
   logic [4:0] tick2;
   int         vec = 0, bad = 0, early;

   tick_scheduler_if #(.CHW(2), .CW(24)) cfg ();
   tick_scheduler_if #(.CHW(3), .CW(8))  cfg2 ();

   tick_scheduler #(.NCH(4), .CW(24), .DEF_PERIOD(24'd20)) dut (
      .clk(clk), .clr_n(clr_n), .run_i(run), .sync_req_i(sync_req),
      .cfg(cfg), .tick_o(tick), .state_o(state));

   tick_scheduler #(.NCH(5), .CW(8), .DEF_PERIOD(8'd3)) dut2 (
      .clk(clk), .clr_n(clr_n), .run_i(run2), .sync_req_i(1'b0),
      .cfg(cfg2), .tick_o(tick2), .state_o(state2));

   always #5 clk = ~clk;

   task automatic step(input int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vec++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic wr(input logic [1:0] ch, input logic [23:0] p);
      cfg.cfg_ch = ch; cfg.cfg_period = p; cfg.cfg_valid = 1'b1;
      step(1);
      cfg.cfg_valid = 1'b0;
   endtask

   initial begin
      cfg.cfg_valid = 1'b0; cfg.cfg_ch = '0; cfg.cfg_period = '0;
      cfg2.cfg_valid = 1'b0; cfg2.cfg_ch = '0; cfg2.cfg_period = '0;
      step(3);
      chk("rst_state", state, 0);
      chk("rst_tick", tick, 0);
      chk("rst_ready", cfg.cfg_ready, 0);
      chk("rst_err", cfg.cfg_err, 0);
      clr_n = 1'b1;
      step(1);
      chk("idle_state", state, 0);
      chk("idle_ready", cfg.cfg_ready, 1);
      // default period: all channels tick together 20 edges after entering RUN
      run = 1'b1;
      step(1);
      chk("run_state", state, 1);
      early = 0;
      for (int k = 1; k < 20; k++) begin step(1); early += int'(tick != 0); end
      chk("def_early", early, 0);
      step(1); chk("def_tick", tick, 4'hF);
      step(1); chk("def_after", tick, 0);
      // ch1 period 5 written on edge 22; others keep phase and tick at edge 40
      wr(2'd1, 24'd5);
      chk("wr_suppress", tick, 0);
      for (int k = 23; k <= 41; k++) begin
         step(1);
         exp4 = {k == 40, k == 40, (k - 22) % 5 == 0, k == 40};
         chk($sformatf("p5_k%0d", k), tick, exp4);
      end
      // ch2 period 10, pause at cnt 6 for 20 cycles, resume
      wr(2'd2, 24'd10);
      step(6);
      run = 1'b0;
      step(1);
      chk("pause_state", state, 2);
      chk("pause_tick", tick, 0);
      early = 0;
      for (int k = 0; k < 19; k++) begin step(1); early += int'(tick != 0 || state != 2); end
      chk("pause_hold", early, 0);
      run = 1'b1;
      step(1);
      chk("resume_state", state, 1);
      chk("resume_edge", tick[2], 0);
      for (int k = 1; k <= 4; k++) begin step(1); chk($sformatf("resume_k%0d", k), tick[2], k == 4); end
      // drop run exactly when ch2 is due: the tick is held off until after resume
      step(9);
      run = 1'b0;
      step(1);
      chk("due_pause_tick", tick[2], 0);
      chk("due_pause_state", state, 2);
      run = 1'b1;
      step(1);
      chk("due_resume_edge", tick[2], 0);
      step(1);
      chk("due_resume_tick", tick[2], 1);
      // ch0 P=3 and ch1 P=7 written on different edges, then realigned by sync
      cfg.cfg_ch = 2'd0; cfg.cfg_period = 24'd3; cfg.cfg_valid = 1'b1;
      step(1);
      cfg.cfg_ch = 2'd1; cfg.cfg_period = 24'd7;
      step(1);
      cfg.cfg_valid = 1'b0;
      step(2);
      sync_req = 1'b1;
      step(1);
      sync_req = 1'b0;
      chk("sync_state", state, 3);
      chk("sync_ready", cfg.cfg_ready, 0);
      chk("sync_tick", tick, 0);
      step(1);
      chk("sync_exit_state", state, 1);
      chk("sync_exit_ready", cfg.cfg_ready, 1);
      for (int k = 1; k <= 8; k++) begin
         step(1);
         chk($sformatf("sync_k%0d", k), tick[1:0], {k == 7, k % 3 == 0});
      end
      // P=1 ticks every RUN edge after the write; P=0 never ticks
      cfg.cfg_ch = 2'd3; cfg.cfg_period = 24'd1; cfg.cfg_valid = 1'b1;
      step(1);
      chk("p1_suppress", tick[3], 0);
      cfg.cfg_ch = 2'd2; cfg.cfg_period = 24'd0;
      step(1);
      cfg.cfg_valid = 1'b0;
      chk("p1_p0_first", tick[3:2], 2'b10);
      early = 0;
      for (int k = 0; k < 12; k++) begin step(1); early += int'(tick[3:2] != 2'b10); end
      chk("p1_p0_run", early, 0);
      // out-of-range channel on the 5-channel instance: error pulse, phases untouched
      run2 = 1'b1;
      step(1);
      cfg2.cfg_ch = 3'd5; cfg2.cfg_period = 8'd9; cfg2.cfg_valid = 1'b1;
      step(1);
      cfg2.cfg_valid = 1'b0;
      chk("err_pulse", cfg2.cfg_err, 1);
      chk("err_tick_k1", tick2, 0);
      step(1);
      chk("err_clear", cfg2.cfg_err, 0);
      step(1);
      chk("err_no_change", tick2, 5'h1F);
      cfg2.cfg_ch = 3'd4; cfg2.cfg_period = 8'd2; cfg2.cfg_valid = 1'b1;
      step(1);
      cfg2.cfg_valid = 1'b0;
      chk("inrange_no_err", cfg2.cfg_err, 0);
      // asynchronous reset while ch3 (P=1) is ticking
      chk("pre_reset_tick", tick[3], 1);
      #2 clr_n = 1'b0;
      #1;
      chk("async_tick", tick, 0);
      chk("async_state", state, 0);
      chk("async_ready", cfg.cfg_ready, 0);
      clr_n = 1'b1;
      step(1);
      chk("rerun_state", state, 1);
      early = 0;
      for (int k = 1; k < 20; k++) begin step(1); early += int'(tick != 0); end
      chk("rerun_early", early, 0);
      step(1);
      chk("rerun_def_tick", tick, 4'hF);
      $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
      $finish;
   end
endmodule
